// File: rtl/wide_rr_arbiter.sv
// Round-robin arbiter feeding one registered WIDTH-bit output stage, with beat counter.
// Optional grant locking for multi-beat packets: define WIDE_RR_ARBITER_LOCK_EN.
module wide_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 128,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
`ifdef WIDE_RR_ARBITER_LOCK_EN
    input  logic [N_REQ-1:0]         req_last,
`endif
    output logic [N_REQ-1:0]         req_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(N_REQ)-1:0] out_id,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         beat_count
);
    localparam int ID_W = $clog2(N_REQ);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [ID_W-1:0]  r_out_id;
    logic [ID_W-1:0]  r_ptr;
    logic [CNT_W-1:0] r_beat_cnt;

    logic             w_load;
    logic [N_REQ-1:0] w_elig;
    logic             w_found;
    logic [ID_W-1:0]  w_gnt_id;
    logic             w_acc;
    logic [ID_W-1:0]  w_ptr_nxt;

    assign w_load = ~r_out_valid | out_ready;

`ifdef WIDE_RR_ARBITER_LOCK_EN
    typedef enum logic {ARB, LOCK} state_t;
    state_t          r_state, w_state_nxt;
    logic [ID_W-1:0] r_lock_id, w_lock_nxt;

    // While locked, everyone but the lock owner is masked out, even if the owner is idle.
    assign w_elig = (r_state == LOCK) ? (req_valid & (N_REQ'(1) << r_lock_id)) : req_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ARB;
            r_lock_id <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_id <= w_lock_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock_id;
        case (r_state)
            ARB: begin
                if (w_acc && !req_last[w_gnt_id]) begin
                    w_state_nxt = LOCK;
                    w_lock_nxt  = w_gnt_id;
                end
            end
            LOCK: begin
                if (w_acc && req_last[w_gnt_id]) w_state_nxt = ARB;
            end
            default: w_state_nxt = ARB;
        endcase
    end
`else
    assign w_elig = req_valid;
`endif

    // First eligible requester at or after r_ptr, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_gnt_id = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!w_found && w_elig[idx]) begin
                w_found  = 1'b1;
                w_gnt_id = ID_W'(idx);
            end
        end
    end

    assign w_acc     = w_load & w_found & ~reset;
    assign req_ready = w_acc ? (N_REQ'(1) << w_gnt_id) : '0;
    assign w_ptr_nxt = (w_gnt_id == ID_W'(N_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_ptr       <= '0;
            r_beat_cnt  <= '0;
        end else begin
            if (w_acc) begin
                r_out_valid <= 1'b1;
                r_out_data  <= req_data[int'(w_gnt_id)*WIDTH +: WIDTH];
                r_out_id    <= w_gnt_id;
                r_ptr       <= w_ptr_nxt;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (r_out_valid && out_ready) r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_id     = r_out_id;
    assign beat_count = r_beat_cnt;
endmodule

// File: tb/tb_wide_rr_arbiter.sv
// Directed bench for wide_rr_arbiter: reset, single source, round-robin, backpressure,
// mid-stream reset, counter wrap (CNT_W=4 instance) and, when enabled, grant locking.
module tb_wide_rr_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic           out_ready;

    logic [N-1:0]   req_ready, req_ready4;
    logic           out_valid, out_valid4;
    logic [W-1:0]   out_data, out_data4;
    logic [1:0]     out_id, out_id4;
    logic [31:0]    beat_count;
    logic [3:0]     beat_count4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wide_rr_arbiter #(.N_REQ(N), .WIDTH(W), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
`ifdef WIDE_RR_ARBITER_LOCK_EN
        .req_last(req_last),
`endif
        .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
        .out_id(out_id), .out_ready(out_ready), .beat_count(beat_count)
    );

    wide_rr_arbiter #(.N_REQ(N), .WIDTH(W), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
`ifdef WIDE_RR_ARBITER_LOCK_EN
        .req_last(req_last),
`endif
        .req_ready(req_ready4), .out_valid(out_valid4), .out_data(out_data4),
        .out_id(out_id4), .out_ready(out_ready), .beat_count(beat_count4)
    );

    function automatic logic [W-1:0] dval(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '0; req_last = '0; out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 4'b1111; out_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_data !== '0 || out_id !== 2'd0) begin n_bad++; $display("FAIL rst_data got=%h/%0d exp=0/0", out_data, out_id); end
        n_cmp++; if (beat_count !== 32'd0) begin n_bad++; $display("FAIL rst_cnt got=%0d exp=0", beat_count); end
        reset = 1'b0; req_valid = '0; out_ready = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0010; out_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL single_ready got=%b exp=0010", req_ready); end
        tick();
        req_valid = '0;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== dval(1) || out_id !== 2'd1)
            begin n_bad++; $display("FAIL single_out got=%b/%h/%0d exp=1/%h/1", out_valid, out_data, out_id, dval(1)); end
        tick();
        n_cmp++; if (beat_count !== 32'd1 || out_valid !== 1'b0)
            begin n_bad++; $display("FAIL single_drain got=%0d/%b exp=1/0", beat_count, out_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_cmp++; if (req_ready !== (4'b0001 << (k % 4)))
                begin n_bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, 4'b0001 << (k % 4)); end
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_id !== 2'(k % 4) || out_data !== dval(k % 4))
                begin n_bad++; $display("FAIL rr_out[%0d] got=%b/%0d/%h exp=1/%0d/%h", k, out_valid, out_id, out_data, k % 4, dval(k % 4)); end
        end
        req_valid = '0;
        tick();
        n_cmp++; if (beat_count !== 32'd8 || out_valid !== 1'b0)
            begin n_bad++; $display("FAIL rr_count got=%0d/%b exp=8/0", beat_count, out_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b0101; out_ready = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_first got=%b exp=0001", req_ready); end
        tick();
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (req_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== dval(0) || out_id !== 2'd0)
                begin n_bad++; $display("FAIL bp_hold[%0d] got=%b/%b/%h/%0d exp=0000/1/%h/0", k, req_ready, out_valid, out_data, out_id, dval(0)); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_resume got=%b exp=0100", req_ready); end
        tick();
        n_cmp++; if (out_id !== 2'd2 || out_data !== dval(2) || beat_count !== 32'd1)
            begin n_bad++; $display("FAIL bp_next got=%0d/%h/%0d exp=2/%h/1", out_id, out_data, beat_count, dval(2)); end
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_wrap got=%b exp=0001", req_ready); end
        tick();
        req_valid = '0;
        n_cmp++; if (out_id !== 2'd0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_third got=%0d/%b exp=0/1", out_id, out_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b1111; out_ready = 1'b1;
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_ready got=%b exp=0000", req_ready); end
        tick();
        reset = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || beat_count !== 32'd0)
            begin n_bad++; $display("FAIL mid_state got=%b/%0d exp=0/0", out_valid, beat_count); end
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_grant got=%b exp=0001", req_ready); end
        tick();
        req_valid = '0;
        n_cmp++; if (out_id !== 2'd0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_out got=%0d/%b exp=0/1", out_id, out_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        req_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 17; k++) tick();
        req_valid = '0;
        tick();
        n_cmp++; if (beat_count4 !== 4'd1) begin n_bad++; $display("FAIL wrap_cnt4 got=%0d exp=1", beat_count4); end
        n_cmp++; if (beat_count !== 32'd17) begin n_bad++; $display("FAIL wrap_cnt32 got=%0d exp=17", beat_count); end
    endtask

`ifdef WIDE_RR_ARBITER_LOCK_EN
    task automatic test_lock();
        logic [1:0] exp_ids [4];
        int got_n;
        exp_ids = '{2'd2, 2'd2, 2'd2, 2'd0};
        got_n = 0;
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b0100; req_last = 4'b0000;
        tick();
        n_cmp++; if (out_id !== exp_ids[0] || out_valid !== 1'b1) begin n_bad++; $display("FAIL lock_b0 got=%0d exp=2", out_id); end
        req_valid = 4'b0001;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL lock_idle got=%b exp=0000", req_ready); end
        tick();
        req_valid = 4'b0101;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL lock_b1r got=%b exp=0100", req_ready); end
        tick();
        n_cmp++; if (out_id !== exp_ids[1]) begin n_bad++; $display("FAIL lock_b1 got=%0d exp=2", out_id); end
        req_last = 4'b0100;
        tick();
        n_cmp++; if (out_id !== exp_ids[2]) begin n_bad++; $display("FAIL lock_b2 got=%0d exp=2", out_id); end
        req_valid = 4'b0001; req_last = 4'b0000;
        tick();
        req_valid = '0;
        n_cmp++; if (out_id !== exp_ids[3] || out_valid !== 1'b1) begin n_bad++; $display("FAIL lock_b3 got=%0d exp=0", out_id); end
    endtask
`endif

    initial begin
        reset = 1'b1; req_valid = '0; req_last = '0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = dval(i);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_wrap();
`ifdef WIDE_RR_ARBITER_LOCK_EN
        test_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
